// File: rtl/imm_gen_stage_if.sv
// Handshake bundle between the immediate-generator stage and its neighbours.
// master = upstream/downstream driver side, slave = the stage itself.
interface imm_gen_stage_if #(
   parameter int unsigned XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [2:0]      in_imm_src;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_imm;
   logic [31:0]     out_instr;
   logic            out_illegal;

   modport master (
      output in_valid, in_instr, in_imm_src, out_ready,
      input  in_ready, out_valid, out_imm, out_instr, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, in_imm_src, out_ready,
      output in_ready, out_valid, out_imm, out_instr, out_illegal
   );
endinterface

// File: rtl/imm_gen_stage.sv
// RISC-V immediate generator followed by a small result queue.
// The immediate is decoded and sign-extended at enqueue time; each queue
// entry carries the extended immediate, the raw instruction and an
// illegal-format flag.
module imm_gen_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   imm_gen_stage_if.slave bus
);
   localparam int unsigned PW   = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   typedef enum logic [2:0] {
      SRC_I  = 3'b000,
      SRC_S  = 3'b001,
      SRC_B  = 3'b010,
      SRC_U  = 3'b011,
      SRC_J  = 3'b100,
      SRC_Z  = 3'b101,
      SRC_R6 = 3'b110,
      SRC_R7 = 3'b111
   } imm_src_e;

   logic [XLEN-1:0]   mem_imm   [DEPTH];
   logic [31:0]       mem_instr [DEPTH];
   logic              mem_ill   [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [PW:0]       count;
   logic              push;
   logic              pop;
   logic              out_valid_i;
   logic signed [31:0] dec_imm32;
   logic [XLEN-1:0]   dec_imm;
   logic              dec_ill;

   // Decode the 32-bit immediate; bit 31 of every signed format is instr[31],
   // so a single signed widening below covers the XLEN=64 sign extension.
   always_comb begin
      dec_imm32 = '0;
      dec_ill   = 1'b0;
      unique case (imm_src_e'(bus.in_imm_src))
         SRC_I:   dec_imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
         SRC_S:   dec_imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
         SRC_B:   dec_imm32 = {{19{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                               bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
         SRC_U:   dec_imm32 = {bus.in_instr[31:12], 12'b0};
         SRC_J:   dec_imm32 = {{11{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
                               bus.in_instr[20], bus.in_instr[30:21], 1'b0};
         SRC_Z:   dec_imm32 = {27'b0, bus.in_instr[19:15]};
         default: dec_ill   = 1'b1;
      endcase
   end

   assign dec_imm = XLEN'(dec_imm32);

   assign out_valid_i   = (count != '0);
   assign push          = bus.in_valid && bus.in_ready;
   assign pop           = out_valid_i && bus.out_ready;

   assign bus.in_ready    = (count < FULL);
   assign bus.out_valid   = out_valid_i;
   assign bus.out_imm     = out_valid_i ? mem_imm[rd_ptr]   : '0;
   assign bus.out_instr   = out_valid_i ? mem_instr[rd_ptr] : '0;
   assign bus.out_illegal = out_valid_i ? mem_ill[rd_ptr]   : 1'b0;

   // Entry storage: written on an accepted push, never cleared.
   always_ff @(posedge clk) begin
      if (push && !rst && !flush) begin
         mem_imm[wr_ptr]   <= dec_imm;
         mem_instr[wr_ptr] <= bus.in_instr;
         mem_ill[wr_ptr]   <= dec_ill;
      end
   end

   // Queue bookkeeping: reset/flush empty the queue, pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: a 32-bit/DEPTH=2 instance and a
// 64-bit/DEPTH=4 instance sharing clock, reset and flush.
module tb_imm_gen_stage;
   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic flush = 1'b0;
   int   total = 0;
   int   bad   = 0;

   imm_gen_stage_if #(.XLEN(32)) b32 ();
   imm_gen_stage_if #(.XLEN(64)) b64 ();

   imm_gen_stage #(.XLEN(32), .DEPTH(2)) u32 (.clk(clk), .rst(rst), .flush(flush), .bus(b32.slave));
   imm_gen_stage #(.XLEN(64), .DEPTH(4)) u64 (.clk(clk), .rst(rst), .flush(flush), .bus(b64.slave));

   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Push one instruction into the 32-bit instance, check it at the head, then drain it.
   task automatic dec32(input string tag, input logic [31:0] instr, input logic [2:0] src,
                        input logic [31:0] imm, input logic ill);
      b32.in_valid = 1'b1; b32.in_instr = instr; b32.in_imm_src = src; b32.out_ready = 1'b1;
      step();
      b32.in_valid = 1'b0;
      check({tag, "_valid"}, 64'(b32.out_valid), 64'd1);
      check({tag, "_imm"},   64'(b32.out_imm),   64'(imm));
      check({tag, "_instr"}, 64'(b32.out_instr), 64'(instr));
      check({tag, "_ill"},   64'(b32.out_illegal), 64'(ill));
      step();
      check({tag, "_drain"}, 64'(b32.out_valid), 64'd0);
   endtask

   task automatic dec64(input string tag, input logic [31:0] instr, input logic [2:0] src,
                        input logic [63:0] imm);
      b64.in_valid = 1'b1; b64.in_instr = instr; b64.in_imm_src = src; b64.out_ready = 1'b1;
      step();
      b64.in_valid = 1'b0;
      check({tag, "_valid"}, 64'(b64.out_valid), 64'd1);
      check({tag, "_imm"},   b64.out_imm, imm);
      check({tag, "_ill"},   64'(b64.out_illegal), 64'd0);
      step();
      check({tag, "_drain"}, 64'(b64.out_valid), 64'd0);
   endtask

   initial begin
      b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_imm_src = '0; b32.out_ready = 1'b0;
      b64.in_valid = 1'b0; b64.in_instr = '0; b64.in_imm_src = '0; b64.out_ready = 1'b0;

      // Reset state
      step(); step();
      rst = 1'b0;
      check("rst_valid", 64'(b32.out_valid),   64'd0);
      check("rst_ready", 64'(b32.in_ready),    64'd1);
      check("rst_imm",   64'(b32.out_imm),     64'd0);
      check("rst_instr", 64'(b32.out_instr),   64'd0);
      check("rst_ill",   64'(b32.out_illegal), 64'd0);
      check("rst64_rdy", 64'(b64.in_ready),    64'd1);

      // Decode, XLEN=32
      dec32("b_neg",  32'hFE000EE3, 3'b010, 32'hFFFFFFFC, 1'b0);
      dec32("i_neg",  32'hFFF00093, 3'b000, 32'hFFFFFFFF, 1'b0);
      dec32("s_pos",  32'h0020A423, 3'b001, 32'h00000008, 1'b0);
      dec32("u_pos",  32'h123450B7, 3'b011, 32'h12345000, 1'b0);
      dec32("j_pos",  32'h008000EF, 3'b100, 32'h00000008, 1'b0);
      dec32("j_neg",  32'hFFDFF0EF, 3'b100, 32'hFFFFFFFC, 1'b0);
      dec32("z_max",  32'h000F8000, 3'b101, 32'h0000001F, 1'b0);
      dec32("ill7",   32'hFFFFFFFF, 3'b111, 32'h00000000, 1'b1);
      dec32("ill6",   32'h12345678, 3'b110, 32'h00000000, 1'b1);
      dec32("legal",  32'h00500093, 3'b000, 32'h00000005, 1'b0);

      // Decode, XLEN=64
      dec64("i64_neg", 32'hFFF00093, 3'b000, 64'hFFFFFFFFFFFFFFFF);
      dec64("u64_neg", 32'h800000B7, 3'b011, 64'hFFFFFFFF80000000);
      dec64("z64_max", 32'h000F8000, 3'b101, 64'h000000000000001F);
      dec64("b64_neg", 32'hFE000EE3, 3'b010, 64'hFFFFFFFFFFFFFFFC);

      // Full / backpressure on the DEPTH=2 instance: A, B, C with out_ready low
      b32.out_ready = 1'b0; b32.in_imm_src = 3'b000;
      b32.in_valid = 1'b1; b32.in_instr = 32'h00100093;
      step();
      check("bp_rdy1",   64'(b32.in_ready),  64'd1);
      check("bp_headA",  64'(b32.out_instr), 64'h00100093);
      b32.in_instr = 32'h00200093;
      step();
      check("bp_full",   64'(b32.in_ready),  64'd0);
      b32.in_instr = 32'h00300093;
      step();
      check("bp_hold_r", 64'(b32.in_ready),  64'd0);
      check("bp_holdA",  64'(b32.out_imm),   64'd1);
      b32.out_ready = 1'b1;
      step();
      check("bp_outB",   64'(b32.out_imm),   64'd2);
      check("bp_rdy2",   64'(b32.in_ready),  64'd1);
      step();
      b32.in_valid = 1'b0;
      check("bp_outC",   64'(b32.out_imm),   64'd3);
      check("bp_validC", 64'(b32.out_valid), 64'd1);
      step();
      check("bp_empty",  64'(b32.out_valid), 64'd0);

      // Streaming: one result per cycle after a single-cycle fill
      b32.in_valid = 1'b1; b32.out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         b32.in_instr = {12'(i + 1), 20'h00093};
         step();
         check("st_imm",   64'(b32.out_imm),   64'(i + 1));
         check("st_valid", 64'(b32.out_valid), 64'd1);
         check("st_ready", 64'(b32.in_ready),  64'd1);
      end
      b32.in_valid = 1'b0;
      step();
      check("st_empty", 64'(b32.out_valid), 64'd0);

      // Flush with two entries queued and a push offered
      b32.out_ready = 1'b0; b64.out_ready = 1'b0;
      b32.in_valid = 1'b1; b64.in_valid = 1'b1;
      b32.in_instr = 32'h00700093; b64.in_instr = 32'h00700093;
      b32.in_imm_src = 3'b000; b64.in_imm_src = 3'b000;
      step(); step();
      check("fl_pre32", 64'(b32.in_ready), 64'd0);
      check("fl_pre64", 64'(b64.out_valid), 64'd1);
      flush = 1'b1; b64.out_ready = 1'b1;
      step();
      flush = 1'b0; b32.in_valid = 1'b0; b64.in_valid = 1'b0;
      check("fl_v32",  64'(b32.out_valid), 64'd0);
      check("fl_r32",  64'(b32.in_ready),  64'd1);
      check("fl_v64",  64'(b64.out_valid), 64'd0);
      check("fl_imm64", b64.out_imm,       64'd0);
      step();
      check("fl_nopush64", 64'(b64.out_valid), 64'd0);

      // After flush the queue restarts from a clean pointer
      dec32("post_fl", 32'h00900093, 3'b000, 32'h00000009, 1'b0);

      // Reset mid-stream with two entries queued and a push offered
      b32.out_ready = 1'b0; b64.out_ready = 1'b0;
      b32.in_valid = 1'b1; b64.in_valid = 1'b1;
      b32.in_instr = 32'hFFF00093; b64.in_instr = 32'hFFF00093;
      step(); step();
      check("rs_pre32", 64'(b32.out_valid), 64'd1);
      rst = 1'b1; flush = 1'b1;
      step();
      rst = 1'b0; flush = 1'b0; b32.in_valid = 1'b0; b64.in_valid = 1'b0;
      check("rs_v32",   64'(b32.out_valid),   64'd0);
      check("rs_r32",   64'(b32.in_ready),    64'd1);
      check("rs_imm32", 64'(b32.out_imm),     64'd0);
      check("rs_ins32", 64'(b32.out_instr),   64'd0);
      check("rs_ill32", 64'(b32.out_illegal), 64'd0);
      check("rs_v64",   64'(b64.out_valid),   64'd0);
      step();
      check("rs_nopush", 64'(b32.out_valid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/imm_gen_stage.md
IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, output immediate width; legal values are 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 2, result queue entries; must be a power of 2 in the range 2..8.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1 bit: synchronous discard of all queued entries.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream offers an instruction.
REQ-007 SHALL have port in_ready, output, 1 bit: stage accepts the offered instruction this cycle.
REQ-008 SHALL have port in_instr, input, 32 bits: raw RISC-V instruction word.
REQ-009 SHALL have port in_imm_src, input, 3 bits: immediate format select.
REQ-010 SHALL have port out_valid, output, 1 bit: queue head is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream consumes the head this cycle.
REQ-012 SHALL have port out_imm, output, XLEN bits: extended immediate of the head entry.
REQ-013 SHALL have port out_instr, output, 32 bits: instruction word of the head entry.
REQ-014 SHALL have port out_illegal, output, 1 bit: head entry used an unsupported in_imm_src.

Function
REQ-015 SHALL use these in_imm_src encodings: 000 I = instr[31:20]; 001 S = {instr[31:25],instr[11:7]}; 010 B = {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}; 011 U = {instr[31:12],12'b0}; 100 J = {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}; 101 Z = instr[19:15] zero-extended.
REQ-016 SHALL sign-extend I, S, B, U and J to XLEN from instr[31], including U when XLEN=64.
REQ-017 SHALL, for in_imm_src 110 or 111, store immediate 0 with out_illegal=1; all other codes store out_illegal=0.
REQ-018 SHALL compute the immediate at enqueue and store it, together with the instruction and illegal flag, in the queue entry.
REQ-019 SHALL enqueue on a cycle where in_valid && in_ready, and dequeue on a cycle where out_valid && out_ready.
REQ-020 SHALL drive in_ready = (count < DEPTH), with no combinational dependence on out_ready; a full queue accepts nothing even when popped in the same cycle.
REQ-021 SHALL drive out_valid = (count != 0); out_imm, out_instr and out_illegal reflect the head entry and hold stable while out_valid && !out_ready.
REQ-022 SHALL have a latency of 1 cycle: an entry accepted into an empty queue at edge N is presented with out_valid=1 after edge N.
REQ-023 SHALL apply a simultaneous push and pop with 0 < count < DEPTH by advancing both pointers and leaving count unchanged.
REQ-024 SHALL deliver entries in strict FIFO order, with read and write pointers wrapping modulo DEPTH.
REQ-025 SHALL, when flush=1 at an edge, set count and both pointers to 0 and ignore any push or pop in that cycle.
REQ-026 SHALL implement count as a $clog2(DEPTH)+1 bit register that never exceeds DEPTH and never underflows.
REQ-027 SHALL drive out_imm, out_instr and out_illegal to 0 when the queue is empty.

Reset
REQ-028 SHALL, with rst=1 at an edge, clear count and pointers, giving out_valid=0, in_ready=1, out_imm=0, out_instr=0 and out_illegal=0; rst takes priority over flush, push and pop.
REQ-029 SHALL, when rst is asserted mid-stream, discard all queued entries; queue storage contents need not be cleared.

Verification
REQ-030 SHALL cover decode: instr 0xFE000EE3 src 010 -> 0xFFFFFFFC; 0xFFF00093 src 000 -> 0xFFFFFFFF; 0x0020A423 src 001 -> 0x00000008; 0x123450B7 src 011 -> 0x12345000.
REQ-031 SHALL cover XLEN=64: 0xFFF00093 src 000 -> 0xFFFFFFFFFFFFFFFF; 0x800000B7 src 011 -> 0xFFFFFFFF80000000; src 101 with instr[19:15]=11111 -> 0x1F.
REQ-032 SHALL cover full/backpressure: DEPTH=2, out_ready=0, 3 back-to-back pushes A,B,C -> in_ready=0 after the 2nd push, C held; then out_ready=1 -> outputs A, B, C in order with no loss or duplication.
REQ-033 SHALL cover streaming: in_valid=1 and out_ready=1 continuously for 20 cycles -> one result per cycle after a 1-cycle fill, count constant at 1.
REQ-034 SHALL cover flush and reset: queue holding 2 entries, flush=1 together with in_valid=1 -> next cycle out_valid=0, nothing enqueued; repeat with rst=1 -> same result plus outputs 0.
REQ-035 SHALL cover illegal source: src 111, any instr -> out_illegal=1, out_imm=0; the following legal entry has out_illegal=0.
